// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution layer engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Output extent along one axis; integer division gives the floor.
    function automatic int out_dim(input int in_sz, input int k,
                                   input int stride, input int pad);
        return (in_sz + 2 * pad - k) / stride + 1;
    endfunction

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// K x K multiply-add over one input channel at one output position.
// Latency: purely combinational.
// Backpressure: none; the caller holds inputs stable while it needs the sum.
// Ports: img_ch (one channel of the input map), w_ch (matching kernel slice),
//        out_row/out_col (output coordinates), sum (signed ACC_W result).
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 24,
    parameter int K      = 3,
    parameter int IN_H   = 16,
    parameter int IN_W   = 15,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4
) (
    input  logic        [IN_H-1:0][IN_W-1:0][DATA_W-1:0] img_ch,
    input  logic signed [K-1:0][K-1:0][W_W-1:0]          w_ch,
    input  logic        [ROW_W-1:0]                      out_row,
    input  logic        [COL_W-1:0]                      out_col,
    output logic signed [ACC_W-1:0]                      sum
);

    localparam int PROD_W = DATA_W + W_W + 1;
    localparam int RI_W   = idx_w(IN_H);
    localparam int CI_W   = idx_w(IN_W);
    localparam int KI_W   = idx_w(K);

    // One tap of the window; positions in the padding border contribute 0.
    function automatic logic signed [ACC_W-1:0] tap(input int kr, input int kc);
        int ir;
        int ic;
        logic signed [PROD_W-1:0] px;
        logic signed [PROD_W-1:0] wt;
        logic signed [PROD_W-1:0] prod;
        ir  = int'(out_row) * STRIDE - PAD + kr;
        ic  = int'(out_col) * STRIDE - PAD + kc;
        tap = '0;
        if (ir >= 0 && ir < IN_H && ic >= 0 && ic < IN_W) begin
            // Pixels are unsigned: a zero sign bit makes the product signed-correct.
            px   = PROD_W'($signed({1'b0, img_ch[ir[RI_W-1:0]][ic[CI_W-1:0]]}));
            wt   = PROD_W'($signed(w_ch[kr[KI_W-1:0]][kc[KI_W-1:0]]));
            prod = px * wt;
            tap  = ACC_W'(prod);
        end
    endfunction

    always_comb begin
        sum = '0;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                sum = sum + tap(kr, kc);
            end
        end
    end

endmodule

// File: rtl/conv_layer_engine.sv
// Multi-channel K x K convolution layer with bias and optional ReLU, streaming one pixel at a time.
// Latency: IN_CH accumulate cycles per pixel, then the pixel is presented in EMIT.
// Backpressure: out_valid/out_ready; pixel and coordinates hold until accepted.
// Ports: start/relu_en launch a layer; in_img/w/bias are held stable for the layer;
//        busy/done report progress; out_* carry the result pixel stream.
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 24,
    parameter int K      = 3,
    parameter int IN_H   = 16,
    parameter int IN_W   = 15,
    parameter int IN_CH  = 1,
    parameter int OUT_CH = 10,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    localparam int OUT_H = out_dim(IN_H, K, STRIDE, PAD),
    localparam int OUT_W = out_dim(IN_W, K, STRIDE, PAD),
    localparam int OC_W  = idx_w(OUT_CH),
    localparam int ROW_W = idx_w(OUT_H),
    localparam int COL_W = idx_w(OUT_W)
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    input  logic                                                  relu_en,
    input  logic        [IN_CH-1:0][IN_H-1:0][IN_W-1:0][DATA_W-1:0] in_img,
    input  logic signed [OUT_CH-1:0][IN_CH-1:0][K-1:0][K-1:0][W_W-1:0] w,
    input  logic signed [OUT_CH-1:0][ACC_W-1:0]                   bias,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic signed [ACC_W-1:0]                               out_data,
    output logic        [OC_W-1:0]                                out_chan,
    output logic        [ROW_W-1:0]                               out_row,
    output logic        [COL_W-1:0]                               out_col,
    output logic                                                  out_last
);

    localparam int IC_W = idx_w(IN_CH);
    localparam logic [IC_W-1:0]  IC_LAST  = IC_W'(IN_CH - 1);
    localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OUT_CH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);

    state_t                    state_q, state_d;
    logic        [OC_W-1:0]    oc_q, oc_d;
    logic        [ROW_W-1:0]   row_q, row_d;
    logic        [COL_W-1:0]   col_q, col_d;
    logic        [IC_W-1:0]    ic_q, ic_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   out_data_q, out_data_d;
    logic                      relu_q, relu_d;
    logic signed [ACC_W-1:0]   mac_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      is_last;

    conv_window_mac #(
        .DATA_W (DATA_W),
        .W_W    (W_W),
        .ACC_W  (ACC_W),
        .K      (K),
        .IN_H   (IN_H),
        .IN_W   (IN_W),
        .STRIDE (STRIDE),
        .PAD    (PAD),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_mac (
        .img_ch  (in_img[ic_q]),
        .w_ch    (w[oc_q][ic_q]),
        .out_row (row_q),
        .out_col (col_q),
        .sum     (mac_sum)
    );

    assign is_last = (oc_q == OC_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d    = state_q;
        oc_d       = oc_q;
        row_d      = row_q;
        col_d      = col_q;
        ic_d       = ic_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        relu_d     = relu_q;
        // The first input channel seeds the accumulator with the bias.
        acc_next   = ((ic_q == '0) ? bias[oc_q] : acc_q) + mac_sum;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    oc_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                    ic_d    = '0;
                    relu_d  = relu_en;
                end
            end
            ST_CALC: begin
                acc_d = acc_next;
                if (ic_q == IC_LAST) begin
                    ic_d       = '0;
                    state_d    = ST_EMIT;
                    out_data_d = (relu_q && acc_next[ACC_W-1]) ? '0 : acc_next;
                end else begin
                    ic_d = ic_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d = '0;
                                oc_d  = oc_q + 1'b1;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            oc_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            ic_q       <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            relu_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            oc_q       <= oc_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ic_q       <= ic_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            relu_q     <= relu_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = out_valid && is_last;
    assign out_data  = out_data_q;
    assign out_chan  = oc_q;
    assign out_row   = row_q;
    assign out_col   = col_q;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine across four parameter sets.
// Latency: n/a.
// Backpressure: exercises held, random and always-ready out_ready.
module tb_conv_layer_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // ---------------- A: default parameters ----------------
    logic a_start, a_relu, a_ready;
    logic        [0:0][15:0][14:0][7:0]    a_img;
    logic signed [9:0][0:0][2:0][2:0][7:0] a_w;
    logic signed [9:0][23:0]               a_bias;
    logic a_busy, a_done, a_valid, a_last;
    logic signed [23:0] a_data;
    logic [3:0] a_chan, a_row, a_col;

    conv_layer_engine u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .relu_en(a_relu),
        .in_img(a_img), .w(a_w), .bias(a_bias), .busy(a_busy), .done(a_done),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_chan(a_chan), .out_row(a_row), .out_col(a_col), .out_last(a_last)
    );

    // ---------------- B: PAD=1, one output channel ----------------
    logic b_start, b_relu, b_ready;
    logic        [0:0][15:0][14:0][7:0]    b_img;
    logic signed [0:0][0:0][2:0][2:0][7:0] b_w;
    logic signed [0:0][23:0]               b_bias;
    logic b_busy, b_done, b_valid, b_last;
    logic signed [23:0] b_data;
    logic [0:0] b_chan;
    logic [3:0] b_row, b_col;

    conv_layer_engine #(.OUT_CH(1), .PAD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .relu_en(b_relu),
        .in_img(b_img), .w(b_w), .bias(b_bias), .busy(b_busy), .done(b_done),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_chan(b_chan), .out_row(b_row), .out_col(b_col), .out_last(b_last)
    );

    // ---------------- C: STRIDE=2, one output channel ----------------
    logic c_start, c_relu, c_ready;
    logic        [0:0][15:0][14:0][7:0]    c_img;
    logic signed [0:0][0:0][2:0][2:0][7:0] c_w;
    logic signed [0:0][23:0]               c_bias;
    logic c_busy, c_done, c_valid, c_last;
    logic signed [23:0] c_data;
    logic [0:0] c_chan;
    logic [2:0] c_row, c_col;

    conv_layer_engine #(.OUT_CH(1), .STRIDE(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .relu_en(c_relu),
        .in_img(c_img), .w(c_w), .bias(c_bias), .busy(c_busy), .done(c_done),
        .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data),
        .out_chan(c_chan), .out_row(c_row), .out_col(c_col), .out_last(c_last)
    );

    // ---------------- D: two input channels, 4x4 map ----------------
    logic d_start, d_relu, d_ready;
    logic        [1:0][3:0][3:0][7:0]      d_img;
    logic signed [1:0][1:0][2:0][2:0][7:0] d_w;
    logic signed [1:0][23:0]               d_bias;
    logic d_busy, d_done, d_valid, d_last;
    logic signed [23:0] d_data;
    logic [0:0] d_chan, d_row, d_col;

    conv_layer_engine #(.IN_H(4), .IN_W(4), .IN_CH(2), .OUT_CH(2)) u_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .relu_en(d_relu),
        .in_img(d_img), .w(d_w), .bias(d_bias), .busy(d_busy), .done(d_done),
        .out_valid(d_valid), .out_ready(d_ready), .out_data(d_data),
        .out_chan(d_chan), .out_row(d_row), .out_col(d_col), .out_last(d_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full layer on A. Expected pixel = 9 - bstep*oc, clamped at 0 under ReLU.
    task automatic run_a(input bit rnd, input bit bp, input bit relu, input int bstep);
        int n, done_cnt, done_cyc, hold_left, eoc, er, ec, exp;
        bit held;
        logic signed [23:0] snap_d;
        logic [3:0] snap_k, snap_r, snap_c;
        n = 0; done_cnt = 0; done_cyc = -10; hold_left = 0;
        eoc = 0; er = 0; ec = 0; held = 1'b0;
        snap_d = '0; snap_k = '0; snap_r = '0; snap_c = '0;
        for (int oc = 0; oc < 10; oc++) a_bias[oc] = 24'(-bstep * oc);
        @(negedge clk);
        a_relu = relu; a_start = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int cyc = 1; cyc < 30000; cyc++) begin
            if (!rnd && !bp && cyc == 1) begin
                chk("a_calc_valid", 32'(a_valid), 0);
                chk("a_busy_calc", 32'(a_busy), 1);
            end
            if (!rnd && !bp && cyc == 2) chk("a_first_valid", 32'(a_valid), 1);
            if (a_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("a_busy_at_done", 32'(a_busy), 1);
            end
            if (cyc == done_cyc + 1) chk("a_busy_after_done", 32'(a_busy), 0);
            if (bp && !held && n == 5 && a_valid) begin
                held = 1'b1; hold_left = 5;
                snap_d = a_data; snap_k = a_chan; snap_r = a_row; snap_c = a_col;
            end
            if (hold_left > 0) begin
                a_ready = 1'b0;
                if (hold_left < 5) begin
                    chk("a_bp_valid", 32'(a_valid), 1);
                    chk("a_bp_data", 32'(a_data), 32'(snap_d));
                    chk("a_bp_chan", 32'(a_chan), 32'(snap_k));
                    chk("a_bp_row", 32'(a_row), 32'(snap_r));
                    chk("a_bp_col", 32'(a_col), 32'(snap_c));
                end
                hold_left--;
            end else begin
                a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (a_valid && a_ready) begin
                exp = 9 - bstep * eoc;
                if (relu && exp < 0) exp = 0;
                chk("a_data", 32'(a_data), exp);
                chk("a_chan", 32'(a_chan), eoc);
                chk("a_row", 32'(a_row), er);
                chk("a_col", 32'(a_col), ec);
                chk("a_last", 32'(a_last), (n == 1819) ? 1 : 0);
                n++;
                if (ec == 12) begin
                    ec = 0;
                    if (er == 13) begin er = 0; eoc++; end else er++;
                end else ec++;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        a_ready = 1'b1;
        chk("a_pixel_count", n, 1820);
        chk("a_done_once", done_cnt, 1);
        if (bp) chk("a_bp_seen", 32'(held), 1);
        if (!rnd && !bp) chk("a_layer_time", done_cyc, 1820 * 2 + 1);
    endtask

    // PAD=1: each output counts the in-range taps of a 3x3 all-ones window.
    task automatic run_b();
        int n, dc, er, ec, exp;
        n = 0; dc = 0; er = 0; ec = 0;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            if (b_valid) begin
                exp = (3 - ((er == 0) ? 1 : 0) - ((er == 15) ? 1 : 0)) *
                      (3 - ((ec == 0) ? 1 : 0) - ((ec == 14) ? 1 : 0));
                chk("b_data", 32'(b_data), exp);
                chk("b_row", 32'(b_row), er);
                chk("b_col", 32'(b_col), ec);
                chk("b_last", 32'(b_last), (er == 15 && ec == 14) ? 1 : 0);
                n++;
                if (ec == 14) begin ec = 0; er++; end else ec++;
            end
            if (b_done) begin dc++; break; end
            @(negedge clk);
        end
        chk("b_pixel_count", n, 240);
        chk("b_done", dc, 1);
    endtask

    // STRIDE=2: centre-tap kernel on in_img[r][c]=r gives 2r+1.
    task automatic run_c();
        int n, dc, er, ec;
        n = 0; dc = 0; er = 0; ec = 0;
        @(negedge clk); c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        for (int cyc = 1; cyc < 1000; cyc++) begin
            if (c_valid) begin
                chk("c_data", 32'(c_data), 2 * er + 1);
                chk("c_row", 32'(c_row), er);
                chk("c_col", 32'(c_col), ec);
                chk("c_last", 32'(c_last), (er == 6 && ec == 6) ? 1 : 0);
                n++;
                if (ec == 6) begin ec = 0; er++; end else ec++;
            end
            if (c_done) begin dc++; break; end
            @(negedge clk);
        end
        chk("c_pixel_count", n, 49);
        chk("c_done", dc, 1);
    endtask

    // Two input channels: 9*1 + 9*(-2) + 5 = -4, or 0 under ReLU.
    task automatic run_d(input bit relu);
        int n, dc;
        n = 0; dc = 0;
        @(negedge clk); d_relu = relu; d_start = 1'b1;
        @(negedge clk); d_start = 1'b0;
        for (int cyc = 1; cyc < 500; cyc++) begin
            if (cyc == 2) chk("d_valid_c2", 32'(d_valid), 0);
            if (cyc == 3) chk("d_valid_c3", 32'(d_valid), 1);
            if (d_valid) begin
                chk("d_data", 32'(d_data), relu ? 0 : -4);
                chk("d_chan", 32'(d_chan), n / 4);
                n++;
            end
            if (d_done) begin
                dc++;
                chk("d_layer_time", cyc, 8 * 3 + 1);
                break;
            end
            @(negedge clk);
        end
        chk("d_pixel_count", n, 8);
        chk("d_done", dc, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_relu = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_relu = 1'b0; b_ready = 1'b1;
        c_start = 1'b0; c_relu = 1'b0; c_ready = 1'b1;
        d_start = 1'b0; d_relu = 1'b0; d_ready = 1'b1;
        a_img = {240{8'd1}};
        a_w = {90{8'sd1}};
        a_bias = '0;
        b_img = {240{8'd1}};
        b_w = {9{8'sd1}};
        b_bias = '0;
        c_w = '0;
        c_w[0][0][1][1] = 8'sd1;
        c_bias = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 15; c++) c_img[0][r][c] = 8'(r);
        d_img = {32{8'd1}};
        for (int oc = 0; oc < 2; oc++) begin
            d_bias[oc] = 24'sd5;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    d_w[oc][0][i][j] = 8'sd1;
                    d_w[oc][1][i][j] = -8'sd2;
                end
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_last", 32'(a_last), 0);
        chk("rst_data", 32'(a_data), 0);
        chk("rst_chan", 32'(a_chan), 0);
        chk("rst_row", 32'(a_row), 0);
        chk("rst_col", 32'(a_col), 0);
        rst_n = 1'b1;

        run_a(1'b0, 1'b0, 1'b0, 0);
        run_a(1'b0, 1'b0, 1'b0, 3);
        run_a(1'b0, 1'b0, 1'b1, 3);
        run_a(1'b0, 1'b1, 1'b0, 0);
        run_a(1'b1, 1'b0, 1'b0, 3);

        // Reset in the middle of a layer.
        a_bias = '0;
        @(negedge clk); a_relu = 1'b0; a_start = 1'b1; a_ready = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_busy_pre", 32'(a_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_done", 32'(a_done), 0);
        chk("mid_rst_valid", 32'(a_valid), 0);
        chk("mid_rst_last", 32'(a_last), 0);
        chk("mid_rst_data", 32'(a_data), 0);
        chk("mid_rst_chan", 32'(a_chan), 0);
        chk("mid_rst_row", 32'(a_row), 0);
        chk("mid_rst_col", 32'(a_col), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(a_done), 0);
            chk("mid_idle", 32'(a_busy), 0);
        end
        run_a(1'b0, 1'b0, 1'b0, 0);

        run_b();
        run_c();
        run_d(1'b0);
        run_d(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_engine.md
# conv_layer_engine

Parametrised convolution layer engine: multi-channel input feature map, K×K kernels, stride, zero padding, per-output-channel bias and optional ReLU. Output pixels stream out one at a time on a valid/ready handshake instead of being written into a full output buffer. It sits between the image/feature buffer and the next layer (pooling or the following conv), and replaces single-channel, stride-1, unpadded first-layer convolution.

## Interface
- DATA_W, 8, unsigned input pixel width
- W_W, 8, signed weight width
- ACC_W, 24, signed accumulator, bias and output width
- K, 3, square kernel size
- IN_H, 16, input height
- IN_W, 15, input width
- IN_CH, 1, input channels
- OUT_CH, 10, output channels
- STRIDE, 1, window step, 1..K
- PAD, 0, zero-padding on each border, 0..K-1
- Derived: OUT_H = (IN_H+2·PAD-K)/STRIDE+1 and OUT_W = (IN_W+2·PAD-K)/STRIDE+1, both floor.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- relu_en  in  1  clamp negative results to 0; sampled at start
- in_img  in  [IN_CH][IN_H][IN_W]×DATA_W  input map, stable from start to done
- w  in  signed [OUT_CH][IN_CH][K][K]×W_W  weights, stable from start to done
- bias  in  signed [OUT_CH]×ACC_W  per-channel bias, stable from start to done
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse after the last handshake
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_data  out  signed ACC_W  result pixel
- out_chan, out_row, out_col  out  clog2 of OUT_CH/OUT_H/OUT_W  pixel coordinates
- out_last  out  1  marks the final pixel of the layer

## Operation
- FSM states:
  - IDLE: start=1 → CALC; reset oc/row/col/ic to 0; latch relu_en.
  - CALC: one cycle per input channel ic. acc ← (ic==0 ? bias[oc] : acc) + window_mac(ic). After ic==IN_CH-1 → EMIT.
  - EMIT: out_valid=1, outputs held stable. On out_valid&&out_ready, advance col, then row, then oc, and go to CALC; from the last pixel go to DONE.
  - DONE: done=1 for one cycle → IDLE.
- Emission order: channel-major, then row, then column.
- Window origin for output (r,c) is (r·STRIDE-PAD, c·STRIDE-PAD). Taps outside [0,IN_H)×[0,IN_W) read as 0.
- Products: zero-extended pixel × signed weight. The K·K sum and the accumulation are sign-extended to ACC_W and wrap on overflow. Sizing ACC_W to avoid overflow is the integrator's responsibility.
- out_data = relu_en && acc<0 ? 0 : acc. Registered on CALC→EMIT entry.
- start while busy is ignored.
- Reset mid-layer: the in-flight layer is discarded and no done pulse is produced.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_chan=0, out_row=0, out_col=0; state=IDLE.
- start high in cycle 0 → CALC in cycles 1..IN_CH → out_valid rises in cycle IN_CH+1.
- With out_ready held at 1: one pixel per IN_CH+1 cycles. Layer time is OUT_CH·OUT_H·OUT_W·(IN_CH+1)+2 cycles including IDLE exit and DONE.
- Handshake: once raised, out_valid stays high and out_data/coordinates stay frozen until out_ready=1. out_valid drops in the cycle after the handshake.
- done is asserted in the cycle after the final handshake. busy falls together with done's deassertion.
- out_last is high only alongside the final pixel (oc=OUT_CH-1, row=OUT_H-1, col=OUT_W-1).

## Structure
- Package conv_pkg: the OUT_H/OUT_W derivation functions, FSM state enum, clog2-width helpers.
- Sub-module conv_window_mac: combinational K×K multiply-add. It takes the window origin, channel slices of in_img and w, and PAD handling, and returns a signed ACC_W sum.
- Top level holds the FSM, counters, accumulator and output register.

## Test plan
- Defaults, all pixels 1, all weights 1, bias 0 → every out_data=9. 1820 pixels emitted (10×14×13); out_last only on the final one; done exactly once.
- PAD=1, OUT 16×15, same data → corner pixels=4, edge pixels=6, interior pixels=9.
- STRIDE=2, PAD=0 → OUT_H=7, OUT_W=7. With in_img[r][c]=r and a centre-tap-only weight of 1, out(r,c)=2r+1.
- IN_CH=2, weights +1 on channel 0 and -2 on channel 1, pixels 1, bias 5 → 9-18+5=-4 with relu_en=0. Same stimulus with relu_en=1 → 0.
- Backpressure: out_ready low for 5 cycles during EMIT → out_valid, data and coordinates unchanged. Random out_ready → sequence identical to the always-ready run.
- rst_n pulsed low mid-layer → all outputs at reset values immediately, no done pulse. A fresh start afterwards gives a complete, correct layer.
